sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, number of cycles oe_n or we_n is held low per access (1..7).
REQ-002 Parameter ADDR_W, default 20, width of the SRAM word address.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high (rst == `RstEnable).
REQ-005 ce_i  in  1  request valid from the MEM stage (mem_ce_o).
REQ-006 we_i  in  1  1 = write, 0 = read (mem_we_o, already exception-gated).
REQ-007 addr_i  in  32  physical byte address (mem_addr_o).
REQ-008 sel_i  in  4  byte lanes, big-endian: sel_i[3] = bits 31:24 = byte offset 00.
REQ-009 data_i  in  32  store data, already lane-replicated.
REQ-010 data_o  out  32  read data returned to the MEM stage (mem_data_i).
REQ-011 stallreq_o  out  1  pipeline stall request while an access is in progress.
REQ-012 sram_addr_o  out  ADDR_W  word address = addr_i[ADDR_W+1:2].
REQ-013 sram_data_o  out  32  write data toward the SRAM pads.
REQ-014 sram_data_i  in  32  read data from the SRAM pads.
REQ-015 sram_data_oe_o  out  1  1 = drive the pads with sram_data_o.
REQ-016 sram_be_n_o  out  4  active-low byte enables, = ~sel latched.
REQ-017 sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low SRAM strobes.

Function
REQ-018 FSM states: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, DONE.
REQ-019 IDLE, ce_i=1: latch addr, sel, data and we. Go to WR_SETUP if we_i=1, else to RD_WAIT.
REQ-020 stallreq_o = 1 in IDLE with ce_i=1, and in RD_WAIT, WR_SETUP and WR_PULSE; 0 in DONE and in idle IDLE.
REQ-021 RD_WAIT: ce_n=0, oe_n=0 for WAIT_CYCLES cycles (3-bit counter). On the last cycle, register sram_data_i into data_o and go to DONE.
REQ-022 WR_SETUP: one cycle with ce_n=0, we_n=1, data_oe=1; then go to WR_PULSE.
REQ-023 WR_PULSE: we_n=0 for WAIT_CYCLES cycles; then go to DONE.
REQ-024 DONE: one cycle with strobes high and stallreq_o=0, so the pipeline advances. data_oe stays 1 after a write (hold time). Always return to IDLE.
REQ-025 Read latency at WAIT_CYCLES=1: request cycle plus 1 stall cycle; data_o is valid in DONE and held until the next read completes.
REQ-026 A write never changes data_o.
REQ-027 The latched request is used for the whole access. Changes on ce_i, addr_i or we_i mid-access (flush, exception) are ignored and the access completes (no torn writes).
REQ-028 A request is accepted only in IDLE. ce_i in DONE belongs to the finishing access. Back-to-back requests therefore cost one IDLE cycle each.
REQ-029 sel latched = 0000 on a write: the full sequence runs with be_n=1111 and no byte is modified.
REQ-030 The counter saturates. It is reloaded on every state entry, with no wrap-around.

Reset
REQ-031 rst=1 at a clock edge: state=IDLE, counter=0, data_o=`ZeroWord, stallreq_o=0, all strobes=1, be_n=1111, data_oe=0, sram_addr_o=0, sram_data_o=0.
REQ-032 rst asserted mid-access aborts the access immediately. we_n rises at that edge and the write outcome is undefined.
REQ-033 The first request after rst deasserts is accepted in the first IDLE cycle.

Structure
REQ-034 FSM state encodings, `ChipEnable, `WriteEnable and `ZeroWord live in the shared defines.v.
REQ-035 No sub-module: a single module.

Verification
REQ-036 Read sel=1111, addr 0x00000104, SRAM word 0x12345678: sram_addr=0x41, oe_n low 1 cycle, data_o=0x12345678 in DONE, stallreq_o high for exactly 2 cycles.
REQ-037 Write sel=0100, addr 0x00000009, data 0xABABABAB: be_n=1011, we_n low 1 cycle after setup; a subsequent read of word 2 returns only byte lane 23:16 changed to 0xAB.
REQ-038 WAIT_CYCLES=3, back-to-back write then read: we_n low 3 cycles, then an IDLE gap, then the read; stall counts are 5 and 4.
REQ-039 ce_i dropped during WR_PULSE: the write still completes and memory is updated; FSM returns to IDLE.
REQ-040 rst pulsed during RD_WAIT: all outputs take their reset values next cycle, data_o=0, stallreq_o=0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding and SRAM strobe polarities
package sram_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_SETUP, WR_PULSE, DONE} state_t;
    localparam logic CHIP_ENABLE = 1'b0;
    localparam logic WRITE_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous SRAM access sequencer for the MEM stage with pipeline stall
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [3:0]        sel_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_data_oe_o,
    output logic [3:0]        sram_be_n_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);
    localparam logic [2:0] LAST = 3'(WAIT_CYCLES - 1);
    state_t state, state_n;
    logic [2:0] cnt;
    logic we_q;
    logic [3:0] sel_q;
    logic last, busy;
    logic unused;
    assign unused = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
    assign last = cnt >= LAST;
    assign busy = state inside {RD_WAIT, WR_SETUP, WR_PULSE};
    assign sram_be_n_o = ~sel_q;
    // next state and strobes decoded from the current state and the latched request
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = ce_i ? (we_i ? WR_SETUP : RD_WAIT) : IDLE;
            RD_WAIT:  state_n = last ? DONE : RD_WAIT;
            WR_SETUP: state_n = WR_PULSE;
            WR_PULSE: state_n = last ? DONE : WR_PULSE;
            default:  state_n = IDLE;
        endcase
        sram_ce_n_o = busy ? CHIP_ENABLE : ~CHIP_ENABLE;
        sram_oe_n_o = (state == RD_WAIT) ? CHIP_ENABLE : ~CHIP_ENABLE;
        sram_we_n_o = (state == WR_PULSE) ? WRITE_ENABLE : ~WRITE_ENABLE;
        sram_data_oe_o = (state inside {WR_SETUP, WR_PULSE}) || (state == DONE && we_q);
        stallreq_o = !rst && ((state == IDLE && ce_i) || busy);
    end
    // state, per-state saturating counter, request latch and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 3'd0;
            data_o <= ZERO_WORD;
            we_q <= 1'b0;
            sel_q <= 4'b0000;
            sram_addr_o <= '0;
            sram_data_o <= ZERO_WORD;
        end else begin
            state <= state_n;
            cnt <= (state_n != state) ? 3'd0 : (cnt == 3'd7 ? 3'd7 : cnt + 3'd1);
            if (state == IDLE && ce_i) begin
                we_q <= we_i;
                sel_q <= sel_i;
                sram_addr_o <= addr_i[ADDR_W+1:2];
                sram_data_o <= data_i;
            end
            if (state == RD_WAIT && last) data_o <= sram_data_i;
        end
    end
endmodule
